// File: rtl/pipe_pkg.sv
// Shared pipeline sequencing definitions: FSM encodings, XZR index and the
// per-cycle control bundle driven into the pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_MWAIT  = 2'd3
  } pipe_state_e;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] LSTALL = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] MWAIT  = 2'd3;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic idex_bubble;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_IDLE   = pipe_ctl_t'(8'b1111_0000);
  localparam pipe_ctl_t CTL_STALL  = pipe_ctl_t'(8'b0011_1000);
  localparam pipe_ctl_t CTL_FLUSH  = pipe_ctl_t'(8'b1111_0111);
  localparam pipe_ctl_t CTL_FREEZE = pipe_ctl_t'(8'b0000_0000);

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the ID sources and the load in ID/EX.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_read_reg_a,
  input  logic [4:0] id_read_reg_b,
  input  logic       id_uses_b,
  input  logic       ex_memRead,
  input  logic [4:0] ex_write_register,
  output logic       lu
);

  assign lu = ex_memRead && (ex_write_register != XZR) &&
              ((ex_write_register == id_read_reg_a) ||
               (id_uses_b && (ex_write_register == id_read_reg_b)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, memory
// wait freezes, plus performance counters and a sticky memory-timeout flag.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       id_read_reg_a,
  input  logic [4:0]       id_read_reg_b,
  input  logic             id_uses_b,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_write_register,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout,
  output logic [1:0]       state_out
);

  localparam int LSW = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;
  localparam int BW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [LSW-1:0] LS_LOAD   = LSW'(LOAD_STALL_CYCLES - 1);
  localparam logic [BW-1:0]  BUSY_MAX  = BW'(MEM_TIMEOUT);
  localparam logic [BW-1:0]  BUSY_LAST = BW'(MEM_TIMEOUT - 1);

  logic [1:0]     state, state_nxt;
  logic [LSW-1:0] ls_cnt, ls_cnt_nxt;
  logic [BW-1:0]  busy_cnt;
  logic           lu;
  pipe_ctl_t      ctl;

  hazard_detect u_detect (
    .id_read_reg_a     (id_read_reg_a),
    .id_read_reg_b     (id_read_reg_b),
    .id_uses_b         (id_uses_b),
    .ex_memRead        (ex_memRead),
    .ex_write_register (ex_write_register),
    .lu                (lu)
  );

  // A remaining stall count survives a memory freeze, so the continuation is
  // keyed on the count rather than on the LSTALL state alone.
  always_comb begin
    ctl        = CTL_IDLE;
    state_nxt  = RUN;
    ls_cnt_nxt = ls_cnt;
    if (RESET) begin
      ctl        = CTL_FLUSH;
      ls_cnt_nxt = '0;
    end else if (mem_busy) begin
      ctl       = CTL_FREEZE;
      state_nxt = MWAIT;
    end else if (branch_taken) begin
      ctl        = CTL_FLUSH;
      state_nxt  = FLUSH;
      ls_cnt_nxt = '0;
    end else if (ls_cnt != '0) begin
      ctl        = CTL_STALL;
      state_nxt  = LSTALL;
      ls_cnt_nxt = ls_cnt - LSW'(1);
    end else if (lu) begin
      ctl        = CTL_STALL;
      state_nxt  = LSTALL;
      ls_cnt_nxt = LS_LOAD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= RUN;
      ls_cnt       <= '0;
      busy_cnt     <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ls_cnt <= ls_cnt_nxt;
      if (!ctl.pc_write)  stall_cycles <= stall_cycles + CNT_W'(1);
      if (ctl.ifid_flush) flush_count  <= flush_count + CNT_W'(1);
      if (state == MWAIT && mem_busy) begin
        if (busy_cnt != BUSY_MAX)  busy_cnt    <= busy_cnt + BW'(1);
        if (busy_cnt == BUSY_LAST) mem_timeout <= 1'b1;
      end else begin
        busy_cnt <= '0;
      end
    end
  end

  assign pc_write    = ctl.pc_write;
  assign ifid_write  = ctl.ifid_write;
  assign idex_write  = ctl.idex_write;
  assign exmem_write = ctl.exmem_write;
  assign idex_bubble = ctl.idex_bubble;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_flush = ctl.exmem_flush;
  assign state_out   = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (default build plus a two-bubble build).
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  id_read_reg_a, id_read_reg_b, ex_write_register;
  logic        id_uses_b, ex_memRead, branch_taken, mem_busy;

  logic        pc_write, ifid_write, idex_write, exmem_write;
  logic        idex_bubble, ifid_flush, idex_flush, exmem_flush;
  logic [31:0] stall_cycles, flush_count;
  logic        mem_timeout;
  logic [1:0]  state_out;

  logic        pc_write2, ifid_write2, idex_write2, exmem_write2;
  logic        idex_bubble2, ifid_flush2, idex_flush2, exmem_flush2;
  logic [31:0] stall_cycles2, flush_count2;
  logic        mem_timeout2;
  logic [1:0]  state_out2;

  always #5 CLK = ~CLK;

  hazard_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .id_read_reg_a(id_read_reg_a), .id_read_reg_b(id_read_reg_b),
    .id_uses_b(id_uses_b), .ex_memRead(ex_memRead),
    .ex_write_register(ex_write_register),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .mem_timeout(mem_timeout), .state_out(state_out)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(2)) dut2 (
    .CLK(CLK), .RESET(RESET),
    .id_read_reg_a(id_read_reg_a), .id_read_reg_b(id_read_reg_b),
    .id_uses_b(id_uses_b), .ex_memRead(ex_memRead),
    .ex_write_register(ex_write_register),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write2), .ifid_write(ifid_write2), .idex_write(idex_write2),
    .exmem_write(exmem_write2), .idex_bubble(idex_bubble2),
    .ifid_flush(ifid_flush2), .idex_flush(idex_flush2), .exmem_flush(exmem_flush2),
    .stall_cycles(stall_cycles2), .flush_count(flush_count2),
    .mem_timeout(mem_timeout2), .state_out(state_out2)
  );

  // Control byte: {pc, ifid, idex, exmem, bubble, ifid_fl, idex_fl, exmem_fl}
  localparam logic [31:0] C_IDLE  = 32'hF0;
  localparam logic [31:0] C_STALL = 32'h38;
  localparam logic [31:0] C_FLUSH = 32'hF7;
  localparam logic [31:0] C_FRZ   = 32'h00;

  localparam int S_CTL = 0, S_STATE = 1, S_STALL = 2, S_FLUSH = 3, S_TMO = 4;
  localparam int S_CTL2 = 5, S_STATE2 = 6, S_STALL2 = 7;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nfail = 0;

  function automatic logic [31:0] obs(input int s);
    case (s)
      S_CTL:    return 32'({pc_write, ifid_write, idex_write, exmem_write,
                            idex_bubble, ifid_flush, idex_flush, exmem_flush});
      S_STATE:  return 32'(state_out);
      S_STALL:  return stall_cycles;
      S_FLUSH:  return flush_count;
      S_TMO:    return 32'(mem_timeout);
      S_CTL2:   return 32'({pc_write2, ifid_write2, idex_write2, exmem_write2,
                            idex_bubble2, ifid_flush2, idex_flush2, exmem_flush2});
      S_STATE2: return 32'(state_out2);
      S_STALL2: return stall_cycles2;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int s, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sig = s; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic sample();
    exp_t        x;
    logic [31:0] o;
    @(negedge CLK);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs(x.sig);
      ncmp++;
      assert (o === x.exp) else begin
        nfail++;
        $error("FAIL %s: observed %0h expected %0h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic drive(input logic rst, input logic busy, input logic br,
                       input logic mr, input logic [4:0] wr,
                       input logic [4:0] a, input logic [4:0] b, input logic ub);
    @(posedge CLK);
    #1;
    RESET = rst; mem_busy = busy; branch_taken = br; ex_memRead = mr;
    ex_write_register = wr; id_read_reg_a = a; id_read_reg_b = b; id_uses_b = ub;
  endtask

  task automatic do_reset(input string tag);
    drive(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push({tag, "_rst_ctl"}, S_CTL, C_FLUSH);
    sample();
    drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push({tag, "_state"}, S_STATE, 32'd0);
    push({tag, "_stall"}, S_STALL, 32'd0);
    push({tag, "_flush"}, S_FLUSH, 32'd0);
    push({tag, "_tmo"}, S_TMO, 32'd0);
    push({tag, "_ctl"}, S_CTL, C_IDLE);
    sample();
  endtask

  initial begin
    RESET = 1'b1; mem_busy = 0; branch_taken = 0; ex_memRead = 0;
    ex_write_register = 0; id_read_reg_a = 1; id_read_reg_b = 2; id_uses_b = 0;

    do_reset("init");

    // LDUR X2 ; ADD X3,X2,X4
    drive(0, 0, 0, 1, 5'd2, 5'd2, 5'd4, 1);
    push("lu_ctl", S_CTL, C_STALL);
    push("lu_state", S_STATE, 32'd0);
    push("lu2_ctl", S_CTL2, C_STALL);
    sample();
    drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push("lu_after_ctl", S_CTL, C_IDLE);
    push("lu_after_state", S_STATE, 32'd1);
    push("lu_stall", S_STALL, 32'd1);
    push("lu2_second_ctl", S_CTL2, C_STALL);
    push("lu2_state", S_STATE2, 32'd1);
    sample();
    drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push("lu_run_state", S_STATE, 32'd0);
    push("lu_run_stall", S_STALL, 32'd1);
    push("lu2_done_ctl", S_CTL2, C_IDLE);
    push("lu2_stall", S_STALL2, 32'd2);
    sample();
    drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push("lu2_run_state", S_STATE2, 32'd0);
    push("lu2_final_stall", S_STALL2, 32'd2);
    sample();

    // XZR never hazards; reg B only when used
    drive(0, 0, 0, 1, 5'd31, 5'd31, 5'd31, 1);
    push("xzr_ctl", S_CTL, C_IDLE);
    sample();
    drive(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
    push("b_unused_ctl", S_CTL, C_IDLE);
    sample();
    drive(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 1);
    push("b_used_ctl", S_CTL, C_STALL);
    push("b_used_stall", S_STALL, 32'd1);
    sample();

    // branch beats load-use
    do_reset("pre_br");
    drive(0, 0, 1, 1, 5'd2, 5'd2, 5'd4, 1);
    push("br_ctl", S_CTL, C_FLUSH);
    push("br_state", S_STATE, 32'd0);
    sample();
    drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push("br_flush_state", S_STATE, 32'd2);
    push("br_flush_ctl", S_CTL, C_IDLE);
    push("br_count", S_FLUSH, 32'd1);
    push("br_stall", S_STALL, 32'd0);
    sample();
    drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push("br_run_state", S_STATE, 32'd0);
    sample();

    // mem_busy 3 cycles masks a pending branch
    do_reset("pre_busy");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0);
      push("busy_ctl", S_CTL, C_FRZ);
      push("busy_state", S_STATE, (i == 0) ? 32'd0 : 32'd3);
      push("busy_stall", S_STALL, 32'(i));
      push("busy_nflush", S_FLUSH, 32'd0);
      sample();
    end
    drive(0, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0);
    push("busy_drop_ctl", S_CTL, C_FLUSH);
    push("busy_drop_state", S_STATE, 32'd3);
    push("busy_drop_stall", S_STALL, 32'd3);
    sample();
    drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push("busy_fl_state", S_STATE, 32'd2);
    push("busy_fl_count", S_FLUSH, 32'd1);
    push("busy_fl_stall", S_STALL, 32'd3);
    sample();

    // timeout after 255 MWAIT cycles, sticky until reset
    do_reset("pre_tmo");
    drive(0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    for (int p = 1; p <= 300; p++) begin
      @(posedge CLK);
      if (p == 255) begin
        push("tmo_before", S_TMO, 32'd0);
        sample();
      end else if (p == 256) begin
        push("tmo_set", S_TMO, 32'd1);
        push("tmo_state", S_STATE, 32'd3);
        push("tmo_ctl", S_CTL, C_FRZ);
        sample();
      end
    end
    drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push("tmo_drop_ctl", S_CTL, C_IDLE);
    push("tmo_drop_state", S_STATE, 32'd3);
    push("tmo_sticky", S_TMO, 32'd1);
    sample();
    drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push("tmo_run_state", S_STATE, 32'd0);
    push("tmo_sticky2", S_TMO, 32'd1);
    sample();
    do_reset("post_tmo");

    // reset in the middle of a two-cycle stall aborts it
    drive(0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0);
    push("mid_lu2_ctl", S_CTL2, C_STALL);
    sample();
    drive(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push("mid_rst_ctl2", S_CTL2, C_FLUSH);
    sample();
    drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    push("mid_after_ctl2", S_CTL2, C_IDLE);
    push("mid_after_state2", S_STATE2, 32'd0);
    push("mid_after_stall2", S_STALL2, 32'd0);
    sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
